// File: rtl/i2c_slave_byte_ctl.sv
// i2c_slave_byte_ctl: I2C target byte controller.
//   Filters SCL/SDA, detects START/STOP, matches a 7-bit own address, receives and
//   transmits bytes with ACK generation/checking, and exchanges bytes with the local
//   host through single-cycle pulses plus a valid/request handshake.
//
// Optional feature: define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low on a transmit
// underrun until the host supplies a byte. Without it, o_scl_oen is tied high and an
// underrun transmits 8'hFF.
//
// Ports:
//   i_sysclk, i_reset_n        clock, asynchronous active-low reset
//   i_enable                   block enable; low forces idle and releases both lines
//   i_own_addr[6:0]            own target address
//   i_dfsr[5:0]                sample divider, one tick every max(i_dfsr,1) clocks
//   i_scl / o_scl_oen          SCL pad input / active-low output enable
//   i_sda / o_sda_oen          SDA pad input / active-low output enable
//   o_busy                     set on START, cleared on STOP
//   o_addr_match, o_rw         own-address pulse, latched R/W bit (1 = master reads)
//   o_rx_data, o_rx_valid      received byte and its 1-cycle strobe
//   i_nack_next                NAK the byte being received when high at receipt
//   o_tx_req                   pulse: host must supply the next transmit byte
//   i_tx_data, i_tx_valid      transmit byte and its valid flag
//   o_master_nak               pulse: master NAKed a transmitted byte
//   o_stop                     pulse on STOP
module i2c_slave_byte_ctl #(
    parameter int unsigned FILT_DEPTH = 3
) (
    input  logic       i_sysclk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [6:0] i_own_addr,
    input  logic [5:0] i_dfsr,
    input  logic       i_scl,
    output logic       o_scl_oen,
    input  logic       i_sda,
    output logic       o_sda_oen,
    output logic       o_busy,
    output logic       o_addr_match,
    output logic       o_rw,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_nack_next,
    output logic       o_tx_req,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_master_nak,
    output logic       o_stop
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StWaitStop
    } state_e;

    localparam logic [2:0] FiltLast = 3'(FILT_DEPTH - 1);

    // Input synchronisers, idle-high.
    logic scl_s1, scl_s2, sda_s1, sda_s2;

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= i_scl;
            scl_s2 <= scl_s1;
            sda_s1 <= i_sda;
            sda_s2 <= sda_s1;
        end
    end

    // Sample tick divider; a divider value of 0 behaves as 1.
    logic [5:0] div_cnt;
    logic [5:0] div_lim;
    logic       tick;

    always_comb begin
        div_lim = (i_dfsr == 6'd0) ? 6'd1 : i_dfsr;
        tick    = (div_cnt >= div_lim - 6'd1);
    end

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_cnt <= 6'd0;
        end else if (tick) begin
            div_cnt <= 6'd0;
        end else begin
            div_cnt <= div_cnt + 6'd1;
        end
    end

    // Glitch filter: a line follows its synchronised input only after FILT_DEPTH
    // consecutive ticks that all disagree with the current filtered value.
    logic       scl_f, sda_f, scl_p, sda_p;
    logic [2:0] scl_cnt, sda_cnt;

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_p   <= 1'b1;
            sda_p   <= 1'b1;
            scl_cnt <= 3'd0;
            sda_cnt <= 3'd0;
        end else begin
            scl_p <= scl_f;
            sda_p <= sda_f;
            if (tick) begin
                if (scl_s2 != scl_f) begin
                    if (scl_cnt == FiltLast) begin
                        scl_f   <= scl_s2;
                        scl_cnt <= 3'd0;
                    end else begin
                        scl_cnt <= scl_cnt + 3'd1;
                    end
                end else begin
                    scl_cnt <= 3'd0;
                end
                if (sda_s2 != sda_f) begin
                    if (sda_cnt == FiltLast) begin
                        sda_f   <= sda_s2;
                        sda_cnt <= 3'd0;
                    end else begin
                        sda_cnt <= sda_cnt + 3'd1;
                    end
                end else begin
                    sda_cnt <= 3'd0;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    always_comb begin
        scl_rise  = scl_f & ~scl_p;
        scl_fall  = ~scl_f & scl_p;
        // Require SCL high in both cycles so an SDA change coinciding with an SCL edge
        // is never mistaken for a bus condition.
        start_det = scl_f & scl_p & sda_p & ~sda_f;
        stop_det  = scl_f & scl_p & ~sda_p & sda_f;
    end

    state_e     state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       ack_drv;    // ACK slot in progress: SDA has been set for the 9th clock
    logic       load_pend;  // next SCL fall in StTx starts a new byte
    logic       nack_q;
    logic       sda_oen, busy, rw;
    logic [7:0] rx_data;
    logic       addr_match, rx_valid, tx_req, master_nak, stop_p;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    logic       scl_oen;
    logic       stretch;
`endif

    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= StIdle;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            ack_drv    <= 1'b0;
            load_pend  <= 1'b0;
            nack_q     <= 1'b0;
            sda_oen    <= 1'b1;
            busy       <= 1'b0;
            rw         <= 1'b0;
            rx_data    <= 8'h00;
            addr_match <= 1'b0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            master_nak <= 1'b0;
            stop_p     <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
            scl_oen    <= 1'b1;
            stretch    <= 1'b0;
`endif
        end else begin
            addr_match <= 1'b0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            master_nak <= 1'b0;
            stop_p     <= 1'b0;
            if (!i_enable || stop_det || start_det) begin
                sda_oen   <= 1'b1;
                ack_drv   <= 1'b0;
                load_pend <= 1'b0;
                bit_cnt   <= 3'd0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                scl_oen   <= 1'b1;
                stretch   <= 1'b0;
`endif
                if (!i_enable) begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end else if (stop_det) begin
                    state  <= StIdle;
                    busy   <= 1'b0;
                    stop_p <= 1'b1;
                end else begin
                    state <= StAddr;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    StAddr: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                // shreg[6:0] holds the seven address bits received so far
                                if (shreg[6:0] == i_own_addr) begin
                                    addr_match <= 1'b1;
                                    rw         <= sda_f;
                                    tx_req     <= sda_f;
                                    state      <= StAddrAck;
                                end else begin
                                    state <= StWaitStop;
                                end
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall && !ack_drv) begin
                            sda_oen <= 1'b0;
                            ack_drv <= 1'b1;
                        end else if (scl_rise && ack_drv) begin
                            // SDA stays low until the next fall, where the new state
                            // releases it or presents the first transmit bit.
                            ack_drv <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                state     <= StTx;
                                load_pend <= 1'b1;
                            end else begin
                                state <= StRx;
                            end
                        end
                    end
                    StRx: begin
                        if (scl_fall) begin
                            sda_oen <= 1'b1;
                        end
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {shreg[6:0], sda_f};
                                rx_valid <= 1'b1;
                                nack_q   <= i_nack_next;
                                state    <= StRxAck;
                            end
                        end
                    end
                    StRxAck: begin
                        if (scl_fall && !ack_drv) begin
                            sda_oen <= nack_q;
                            ack_drv <= 1'b1;
                        end else if (scl_rise && ack_drv) begin
                            ack_drv <= 1'b0;
                            state   <= nack_q ? StWaitStop : StRx;
                        end
                    end
                    StTx: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                        if (stretch) begin
                            if (i_tx_valid) begin
                                shreg   <= i_tx_data;
                                sda_oen <= i_tx_data[7];
                                scl_oen <= 1'b1;
                                stretch <= 1'b0;
                            end
                        end else
`endif
                        if (scl_fall) begin
                            if (load_pend) begin
                                load_pend <= 1'b0;
                                bit_cnt   <= 3'd0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                                if (i_tx_valid) begin
                                    shreg   <= i_tx_data;
                                    sda_oen <= i_tx_data[7];
                                end else begin
                                    sda_oen <= 1'b1;
                                    scl_oen <= 1'b0;
                                    stretch <= 1'b1;
                                end
`else
                                shreg   <= i_tx_valid ? i_tx_data : 8'hFF;
                                sda_oen <= i_tx_valid ? i_tx_data[7] : 1'b1;
`endif
                            end else if (bit_cnt == 3'd7) begin
                                sda_oen <= 1'b1;
                                bit_cnt <= 3'd0;
                                state   <= StTxAck;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oen <= shreg[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    StTxAck: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                tx_req    <= 1'b1;
                                load_pend <= 1'b1;
                                state     <= StTx;
                            end else begin
                                master_nak <= 1'b1;
                                state      <= StWaitStop;
                            end
                        end
                    end
                    StWaitStop: sda_oen <= 1'b1;
                    StIdle:     sda_oen <= 1'b1;
                    default:    state   <= StIdle;
                endcase
            end
        end
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign o_scl_oen = scl_oen;
`else
    assign o_scl_oen = 1'b1;
`endif
    assign o_sda_oen    = sda_oen;
    assign o_busy       = busy;
    assign o_addr_match = addr_match;
    assign o_rw         = rw;
    assign o_rx_data    = rx_data;
    assign o_rx_valid   = rx_valid;
    assign o_tx_req     = tx_req;
    assign o_master_nak = master_nak;
    assign o_stop       = stop_p;

endmodule

// File: tb/tb_i2c_slave_byte_ctl.sv
// tb_i2c_slave_byte_ctl: bench for i2c_slave_byte_ctl. A bit-level I2C master drives an
// open-drain bus model; a host process answers transmit requests; expectations come
// from transaction-level rules (address match, ACK/NAK, byte lists).
module tb_i2c_slave_byte_ctl;

    localparam int Q = 12;  // quarter SCL period in clocks

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       enable, nack_next, tx_valid;
    logic [6:0] own_addr;
    logic [5:0] dfsr;
    logic [7:0] tx_data;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_oen, sda_oen, busy, addr_match, rw, rx_valid, tx_req, master_nak, stop;
    logic [7:0] rx_data;
    logic       scl_bus, sda_bus;

    assign scl_bus = m_scl & scl_oen;
    assign sda_bus = m_sda & sda_oen;

    i2c_slave_byte_ctl #(.FILT_DEPTH(3)) dut (
        .i_sysclk    (clk),
        .i_reset_n   (rst_n),
        .i_enable    (enable),
        .i_own_addr  (own_addr),
        .i_dfsr      (dfsr),
        .i_scl       (scl_bus),
        .o_scl_oen   (scl_oen),
        .i_sda       (sda_bus),
        .o_sda_oen   (sda_oen),
        .o_busy      (busy),
        .o_addr_match(addr_match),
        .o_rw        (rw),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_nack_next (nack_next),
        .o_tx_req    (tx_req),
        .i_tx_data   (tx_data),
        .i_tx_valid  (tx_valid),
        .o_master_nak(master_nak),
        .o_stop      (stop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor of DUT pulses and line activity.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] host_q[$];
    int n_match = 0, n_txreq = 0, n_mnak = 0, n_stop = 0, n_busy_rise = 0;
    int n_sda_drv = 0, n_scl_drv = 0, scl_run = 0, stretch_len = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (addr_match) n_match++;
        if (tx_req) n_txreq++;
        if (master_nak) n_mnak++;
        if (stop) n_stop++;
        if (busy && !busy_prev) n_busy_rise++;
        busy_prev = busy;
        if (!sda_oen) n_sda_drv++;
        if (!scl_oen) begin
            n_scl_drv++;
            scl_run++;
        end else begin
            if (scl_run != 0) stretch_len = scl_run;
            scl_run = 0;
        end
    end

    // Host side: answer each transmit request from host_q; in late mode supply
    // late_byte after 501 clocks of stretching.
    logic       late_mode = 1'b0;
    logic [7:0] late_byte = 8'h96;
    int         late_cnt = 0;

    always @(negedge clk) begin
        if (tx_req) begin
            if (host_q.size() > 0) begin
                tx_data  = host_q.pop_front();
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
        end
        if (late_mode && !scl_oen && !tx_valid) begin
            late_cnt++;
            if (late_cnt == 501) begin
                tx_data  = late_byte;
                tx_valid = 1'b1;
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int k = 0;
        m_scl = 1'b1;
        while (scl_bus !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 5000) check_eq("scl_release", scl_bus, 1);
    endtask

    task automatic m_start();
        m_sda = 1'b1; clks(Q); scl_up(); clks(Q);
        m_sda = 1'b0; clks(Q);
        m_scl = 1'b0; clks(Q);
    endtask

    task automatic m_stop();
        m_sda = 1'b0; clks(Q); scl_up(); clks(Q);
        m_sda = 1'b1; clks(2 * Q);
    endtask

    task automatic wr_bit(input logic b);
        m_sda = b; clks(Q); scl_up(); clks(2 * Q);
        m_scl = 1'b0; clks(Q);
    endtask

    task automatic rd_bit(output logic b);
        m_sda = 1'b1; clks(Q); scl_up(); clks(Q);
        b = sda_bus; clks(Q);
        m_scl = 1'b0; clks(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic nk, output logic ack);
        logic a;
        nack_next = nk;
        for (int i = 7; i >= 0; i--) wr_bit(b[i]);
        rd_bit(a);
        ack = ~a;
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic m_ack);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(x);
            b[i] = x;
        end
        wr_bit(~m_ack);
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_eq(tag, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_BEEF, exp_q[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] b;
        int m0, t0, k0, s0, d0, r0;

        enable = 1'b1; nack_next = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        own_addr = 7'h50; dfsr = 6'd1;
        clks(3);
        check_eq("rst_scl_oen", scl_oen, 1);
        check_eq("rst_sda_oen", sda_oen, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rw", rw, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_pulses", {addr_match, rx_valid, tx_req, master_nak, stop}, 0);
        rst_n = 1'b1;
        clks(20);

        // Write 0x3C, 0x7E to own address 0x50.
        m0 = n_match; s0 = n_stop; rx_q.delete();
        m_start();
        wr_byte(8'hA0, 1'b0, ack); check_eq("w1_addr_ack", ack, 1);
        wr_byte(8'h3C, 1'b0, ack); check_eq("w1_d0_ack", ack, 1);
        wr_byte(8'h7E, 1'b0, ack); check_eq("w1_d1_ack", ack, 1);
        check_eq("w1_busy_mid", busy, 1);
        m_stop();
        exp_q = {8'h3C, 8'h7E};
        check_rx("w1_rx");
        check_eq("w1_match", n_match - m0, 1);
        check_eq("w1_rw", rw, 0);
        check_eq("w1_stop", n_stop - s0, 1);
        check_eq("w1_busy_end", busy, 0);

        // Mismatched address 0x52: the target must stay silent.
        m0 = n_match; d0 = n_sda_drv; rx_q.delete();
        m_start();
        wr_byte(8'h52, 1'b0, ack); check_eq("mm_addr_ack", ack, 0);
        wr_byte(8'h11, 1'b0, ack); check_eq("mm_data_ack", ack, 0);
        m_stop();
        check_eq("mm_sda_drive", n_sda_drv - d0, 0);
        check_eq("mm_match", n_match - m0, 0);
        check_eq("mm_rx_count", rx_q.size(), 0);
        m_start();
        wr_byte(8'hA0, 1'b0, ack); check_eq("mm_after_ack", ack, 1);
        m_stop();

        // Read 0x5A, 0xC3; master ACKs then NAKs.
        t0 = n_txreq; k0 = n_mnak;
        host_q = {8'h5A, 8'hC3};
        m_start();
        wr_byte(8'hA1, 1'b0, ack); check_eq("rd_addr_ack", ack, 1);
        rd_byte(b, 1'b1); check_eq("rd_b0", b, 8'h5A);
        rd_byte(b, 1'b0); check_eq("rd_b1", b, 8'hC3);
        m_stop();
        check_eq("rd_txreq", n_txreq - t0, 2);
        check_eq("rd_mnak", n_mnak - k0, 1);
        check_eq("rd_rw", rw, 1);

        // NAK of the 2nd data byte, ignored byte, repeated START read.
        rx_q.delete();
        m_start();
        wr_byte(8'hA0, 1'b0, ack); check_eq("nk_addr_ack", ack, 1);
        wr_byte(8'h11, 1'b0, ack); check_eq("nk_d0_ack", ack, 1);
        wr_byte(8'h22, 1'b1, ack); check_eq("nk_d1_nak", ack, 0);
        wr_byte(8'h33, 1'b0, ack); check_eq("nk_d2_ignored", ack, 0);
        nack_next = 1'b0;
        host_q = {8'h44};
        m_start();
        wr_byte(8'hA1, 1'b0, ack); check_eq("nk_rs_ack", ack, 1);
        rd_byte(b, 1'b0); check_eq("nk_rs_byte", b, 8'h44);
        m_stop();
        exp_q = {8'h11, 8'h22};
        check_rx("nk_rx");

        // Disable while the target drives a 0 data bit.
        host_q = {8'h00};
        m_start();
        wr_byte(8'hA1, 1'b0, ack); check_eq("en_addr_ack", ack, 1);
        check_eq("en_drive_low", sda_oen, 0);
        r0 = n_txreq;
        enable = 1'b0; clks(2);
        check_eq("en_release", sda_oen, 1);
        check_eq("en_busy", busy, 0);
        check_eq("en_no_pulse", n_txreq - r0, 0);
        enable = 1'b1;
        m_stop();

        // Glitch rejection at dfsr=4.
        dfsr = 6'd4; clks(20);
        r0 = n_busy_rise; s0 = n_stop;
        m_sda = 1'b0; clks(8); m_sda = 1'b1; clks(60);
        check_eq("gl_short_start", n_busy_rise - r0, 0);
        check_eq("gl_short_busy", busy, 0);
        m_sda = 1'b0; clks(20); m_sda = 1'b1; clks(60);
        check_eq("gl_long_start", n_busy_rise - r0, 1);
        check_eq("gl_long_stop", n_stop - s0, 1);
        dfsr = 6'd1; clks(20);

        // Transmit underrun.
        d0 = n_scl_drv;
        late_mode = 1'b1; late_cnt = 0;
        m_start();
        wr_byte(8'hA1, 1'b0, ack); check_eq("ur_addr_ack", ack, 1);
        rd_byte(b, 1'b0);
        m_stop();
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        check_eq("ur_stretch_byte", b, 8'h96);
        check_eq("ur_stretch_len", stretch_len, 501);
`else
        check_eq("ur_ff_byte", b, 8'hFF);
        check_eq("ur_no_stretch", n_scl_drv - d0, 0);
`endif
        late_mode = 1'b0; tx_valid = 1'b0;

        // Randomised transactions against the transaction-level model.
        own_addr = 7'($urandom_range(8, 119));
        for (int t = 0; t < 12; t++) begin
            logic [6:0] a;
            logic       r, match, alive, nk;
            int         n;
            logic [7:0] bq[$];
            a = ($urandom_range(0, 1) == 1) ? own_addr : 7'($urandom);
            r = 1'($urandom);
            n = $urandom_range(1, 3);
            match = (a == own_addr);
            m0 = n_match; t0 = n_txreq; k0 = n_mnak; s0 = n_stop;
            rx_q.delete(); exp_q.delete(); bq.delete();
            if (match && r) begin
                for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
                host_q = bq;
            end
            m_start();
            wr_byte({a, r}, 1'b0, ack); check_eq("rnd_addr_ack", ack, match);
            if (ack && r) begin
                for (int i = 0; i < n; i++) begin
                    rd_byte(b, i != n - 1);
                    check_eq("rnd_rd_byte", b, bq[i]);
                end
                check_eq("rnd_txreq", n_txreq - t0, n);
                check_eq("rnd_mnak", n_mnak - k0, 1);
            end else if (ack) begin
                alive = 1'b1;
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    nk = ($urandom_range(0, 3) == 0);
                    wr_byte(b, nk, ack);
                    check_eq("rnd_wr_ack", ack, alive && !nk);
                    if (alive) exp_q.push_back(b);
                    if (nk) alive = 1'b0;
                end
                nack_next = 1'b0;
            end
            m_stop();
            if (!r || !match) check_rx("rnd_rx");
            check_eq("rnd_match", n_match - m0, match ? 1 : 0);
            if (match) check_eq("rnd_rw", rw, r);
            check_eq("rnd_stop", n_stop - s0, 1);
            check_eq("rnd_busy_end", busy, 0);
            host_q.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
